cmd_framer: RTL and testbench

//  Parametrised N-source packet framer feeding the byte-wide TX link (UART/USB bridge).

---
 rtl/cmd_framer_pkg.sv | 25 ++
 rtl/cmd_framer_arb.sv | 33 +++
 rtl/cmd_framer.sv | 159 +++++++++++++++
 tb/tb_cmd_framer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_framer_pkg.sv
// Shared constants for the command framer: state encodings, mode selectors and
// the running checksum step.
package cmd_framer_pkg;

    localparam int         N_SRC_DEFAULT  = 4;
    localparam logic [7:0] PREFIX_DEFAULT = 8'hAA;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PREFIX = 3'd1;
    localparam logic [2:0] ST_SRC    = 3'd2;
    localparam logic [2:0] ST_LEN    = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_CHK    = 3'd5;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;
    localparam int CHK_SUM   = 0;
    localparam int CHK_XOR   = 1;

    function automatic logic [7:0] chk_next(input int mode, input logic [7:0] acc,
                                            input logic [7:0] b);
        return (mode == CHK_XOR) ? (acc ^ b) : (acc + b);
    endfunction

endpackage

// File: rtl/cmd_framer_arb.sv
// Single-cycle arbiter: round-robin starting after ptr, or fixed lowest-index priority.
// Produces a one-hot grant plus its encoded index.
module rr_arbiter
    import cmd_framer_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = ARB_RR,
    parameter int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic          found;
        logic [IW-1:0] sel;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) begin
            sel = (MODE == ARB_FIXED) ? IW'(k) : IW'((int'(ptr) + 1 + k) % N);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/cmd_framer.sv
// N-source packet framer for the byte-wide TX link: PREFIX, SRC, LEN, data, CHK.
// Output register advances only when empty or accepted (valid/ready).
//
// state     | meaning (byte currently held in the output register)
// ----------+------------------------------------------------------
// ST_IDLE   | nothing valid, arbitrating every cycle
// ST_PREFIX | frame start byte
// ST_SRC    | source index byte
// ST_LEN    | payload length byte
// ST_DATA   | payload byte number cnt
// ST_CHK    | checksum byte, tx_last high; re-arbitrates on acceptance
module cmd_framer
    import cmd_framer_pkg::*;
#(
    parameter int         N_SRC    = N_SRC_DEFAULT,
    parameter logic [7:0] PREFIX   = PREFIX_DEFAULT,
    parameter int         ARB_MODE = ARB_RR,
    parameter int         CHK_MODE = CHK_SUM
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   have_msg_bus,
    input  logic [8*N_SRC-1:0] data_bus,
    input  logic [8*N_SRC-1:0] len_bus,
    output logic [N_SRC-1:0]   rdreq_bus,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    output logic               tx_last,
    input  logic               tx_ready,
    output logic               busy
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [2:0]       state;
    logic [IW-1:0]    src;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    arb_ptr;
    logic [IW-1:0]    arb_idx;
    logic [N_SRC-1:0] arb_grant;
    logic             arb_any;
    logic [7:0]       len_lat;
    logic [7:0]       cnt;
    logic [7:0]       chk;
    logic [7:0]       src_byte;
    logic [7:0]       cur_data;
    logic [7:0]       cur_len;
    logic [7:0]       data_arr [N_SRC];
    logic [7:0]       len_arr  [N_SRC];
    logic             load;
    logic             take_data;

    for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
        assign data_arr[g] = data_bus[8*g +: 8];
        assign len_arr[g]  = len_bus[8*g +: 8];
    end

    assign cur_data = data_arr[src];
    assign cur_len  = len_arr[src];

    always_comb begin
        src_byte         = '0;
        src_byte[IW-1:0] = src;
    end

    assign load = !tx_valid || tx_ready;

    // On CHK acceptance the pointer is about to become src, so arbitrate against it now.
    assign arb_ptr = (state == ST_CHK) ? src : rr_ptr;

    rr_arbiter #(
        .N    (N_SRC),
        .MODE (ARB_MODE),
        .IW   (IW)
    ) u_arb (
        .req   (have_msg_bus),
        .ptr   (arb_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign arb_any = |arb_grant;

    assign take_data = load && (((state == ST_LEN) && (len_lat != 8'd0)) ||
                                ((state == ST_DATA) && (cnt != len_lat)));

    always_comb begin
        rdreq_bus = '0;
        if (take_data) begin
            rdreq_bus[src] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            src      <= '0;
            rr_ptr   <= IW'(N_SRC - 1);
            len_lat  <= '0;
            cnt      <= '0;
            chk      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
        end else if (load) begin
            case (state)
                ST_IDLE, ST_CHK: begin
                    if (state == ST_CHK) begin
                        rr_ptr <= src;
                    end
                    chk     <= '0;
                    cnt     <= '0;
                    tx_last <= 1'b0;
                    if (arb_any) begin
                        src      <= arb_idx;
                        tx_data  <= PREFIX;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_PREFIX;
                    end else begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_PREFIX: begin
                    tx_data <= src_byte;
                    chk     <= src_byte;
                    state   <= ST_SRC;
                end
                ST_SRC: begin
                    len_lat <= cur_len;
                    tx_data <= cur_len;
                    chk     <= chk_next(CHK_MODE, chk, cur_len);
                    state   <= ST_LEN;
                end
                ST_LEN, ST_DATA: begin
                    if (take_data) begin
                        tx_data <= cur_data;
                        chk     <= chk_next(CHK_MODE, chk, cur_data);
                        cnt     <= cnt + 8'd1;
                        state   <= ST_DATA;
                    end else begin
                        tx_data <= chk;
                        tx_last <= 1'b1;
                        state   <= ST_CHK;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_framer.sv
// Directed bench for cmd_framer: three instances (sum/RR, xor/RR, sum/fixed) fed from
// behavioural show-ahead sources whose k-th byte is base + k.
module tb_cmd_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  have = '0;
    logic [31:0] lens = '0;
    logic [31:0] bases = '0;
    logic        tx_ready = 1'b1;

    logic [31:0] data_b   [3];
    logic [3:0]  rdreq    [3];
    logic [7:0]  tx_data  [3];
    logic        tx_valid [3];
    logic        tx_last  [3];
    logic        busy     [3];

    logic [7:0]  pops [3][4];
    logic [7:0]  cap_data [3][64];
    int          cap_cyc  [3][64];
    logic [63:0] cap_last [3];
    int          cap_n    [3];
    int          cyc = 0;
    logic        hold_p = 1'b0;
    logic [7:0]  hold_d = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cmd_framer #(.N_SRC(4), .PREFIX(8'hAA), .ARB_MODE(0), .CHK_MODE(0)) dut (
        .clk(clk), .rst(rst), .have_msg_bus(have), .data_bus(data_b[0]), .len_bus(lens),
        .rdreq_bus(rdreq[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_last(tx_last[0]), .tx_ready(tx_ready), .busy(busy[0]));

    cmd_framer #(.N_SRC(4), .PREFIX(8'hAA), .ARB_MODE(0), .CHK_MODE(1)) dut_xor (
        .clk(clk), .rst(rst), .have_msg_bus(have), .data_bus(data_b[1]), .len_bus(lens),
        .rdreq_bus(rdreq[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_last(tx_last[1]), .tx_ready(tx_ready), .busy(busy[1]));

    cmd_framer #(.N_SRC(4), .PREFIX(8'hAA), .ARB_MODE(1), .CHK_MODE(0)) dut_fix (
        .clk(clk), .rst(rst), .have_msg_bus(have), .data_bus(data_b[2]), .len_bus(lens),
        .rdreq_bus(rdreq[2]), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_last(tx_last[2]), .tx_ready(tx_ready), .busy(busy[2]));

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int d = 0; d < 3; d++) begin
            data_b[d] = '0;
            for (int i = 0; i < 4; i++) begin
                data_b[d][8*i +: 8] = bases[8*i +: 8] + pops[d][i];
            end
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (clr) pops[d][i] <= '0;
                else if (rdreq[d][i]) pops[d][i] <= pops[d][i] + 8'd1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Inputs change #1 after posedge, so values seen here are what the next posedge samples.
    always @(negedge clk) begin
        if (clr) begin
            for (int d = 0; d < 3; d++) begin
                cap_n[d]    = 0;
                cap_last[d] = '0;
            end
            hold_p = 1'b0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (tx_valid[d] && tx_ready && cap_n[d] < 64) begin
                    cap_data[d][cap_n[d]] = tx_data[d];
                    cap_last[d][cap_n[d]] = tx_last[d];
                    cap_cyc[d][cap_n[d]]  = cyc;
                    cap_n[d]++;
                end
            end
            if (hold_p) check("stall_hold", {23'd0, tx_valid[0], tx_data[0]}, {23'd0, 1'b1, hold_d});
            if (tx_valid[0] && !tx_ready) check("stall_no_rdreq", {28'd0, rdreq[0]}, 32'd0);
            hold_p = tx_valid[0] && !tx_ready;
            hold_d = tx_data[0];
        end
    end

    typedef struct {
        string        name;
        int           d;
        logic [3:0]   have;
        logic [31:0]  lens;
        logic [31:0]  bases;
        bit           rnd;
        bit           hold;
        int           n;
        logic [199:0] exp;
        logic [24:0]  last_mask;
        bit           chk_pops;
        logic [31:0]  exp_pops;
    } vec_t;

    function automatic vec_t mk(input string nm, input int d, input logic [3:0] hv,
                                input logic [31:0] ln, input logic [31:0] bs, input bit rnd,
                                input bit hold, input int n, input logic [199:0] exp,
                                input logic [24:0] lm, input bit cp, input logic [31:0] ep);
        vec_t v;
        v.name = nm; v.d = d; v.have = hv; v.lens = ln; v.bases = bs; v.rnd = rnd;
        v.hold = hold; v.n = n; v.exp = exp; v.last_mask = lm; v.chk_pops = cp; v.exp_pops = ep;
        return v;
    endfunction

    task automatic do_reset();
        have     = '0;
        tx_ready = 1'b1;
        rst      = 1'b1;
        clr      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [199:0] e;
        logic [63:0]  m;
        bit           done;
        e = v.exp;
        do_reset();
        lens  = v.lens;
        bases = v.bases;
        have  = v.have;
        done  = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk);
            #1;
            tx_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!v.hold && busy[v.d]) have = '0;
            if (cap_n[v.d] >= v.n) done = 1'b1;
        end
        have     = '0;
        tx_ready = 1'b1;
        if (!done) timeout(v.name);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < v.n; k++) begin
            check($sformatf("%s byte%0d", v.name, k), {24'd0, cap_data[v.d][k]},
                  {24'd0, e[8*(v.n-1-k) +: 8]});
        end
        m = (64'd1 << v.n) - 64'd1;
        check($sformatf("%s last_flags", v.name), 32'(cap_last[v.d] & m), 32'(v.last_mask));
        if (v.chk_pops) begin
            check($sformatf("%s rdreq_count", v.name),
                  {pops[v.d][3], pops[v.d][2], pops[v.d][1], pops[v.d][0]}, v.exp_pops);
        end
        if (v.hold) begin
            check($sformatf("%s no_bubble", v.name),
                  32'(cap_cyc[v.d][v.n-1] - cap_cyc[v.d][0]), 32'(v.n - 1));
        end else begin
            check($sformatf("%s idle_after", v.name), {30'd0, busy[v.d], tx_valid[v.d]}, 32'd0);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int start;
        bit found;

        vecs[0] = mk("sum_src2_len3", 0, 4'b0100, 32'h00030000, 32'h00010000, 0, 0, 7,
                     200'hAA02030102030B, 25'h40, 1, 32'h00030000);
        vecs[1] = mk("xor_src2_len3", 1, 4'b0100, 32'h00030000, 32'h00010000, 0, 0, 7,
                     200'hAA020301020301, 25'h40, 1, 32'h00030000);
        vecs[2] = mk("len0_src1", 0, 4'b0010, 32'h00000000, 32'h00005500, 0, 0, 4,
                     200'hAA010001, 25'h8, 1, 32'h00000000);
        vecs[3] = mk("chk_wrap_src3", 0, 4'b1000, 32'h02000000, 32'hF0000000, 0, 0, 6,
                     200'hAA0302F0F1E6, 25'h20, 1, 32'h02000000);
        vecs[4] = mk("rr_all_len1", 0, 4'b1111, 32'h01010101, 32'h40302010, 0, 1, 25,
                     200'hAA00011011_AA01012022_AA02013033_AA03014044_AA00011112,
                     25'h1084210, 0, 32'h0);
        vecs[5] = mk("fixed_all_len1", 2, 4'b1111, 32'h01010101, 32'h40302010, 0, 1, 25,
                     200'hAA00011011_AA00011112_AA00011213_AA00011314_AA00011415,
                     25'h1084210, 0, 32'h0);
        vecs[6] = mk("stall_src2_len3", 0, 4'b0100, 32'h00030000, 32'h00010000, 1, 0, 7,
                     200'hAA02030102030B, 25'h40, 1, 32'h00030000);

        #2;
        rst = 1'b1;
        #1;
        check("reset tx_valid", {31'd0, tx_valid[0]}, 32'd0);
        check("reset tx_data", {24'd0, tx_data[0]}, 32'd0);
        check("reset tx_last", {31'd0, tx_last[0]}, 32'd0);
        check("reset busy", {31'd0, busy[0]}, 32'd0);
        check("reset rdreq", {28'd0, rdreq[0]}, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset while the second payload byte is being popped.
        do_reset();
        bases = 32'h00010000;
        lens  = 32'h00030000;
        have  = 4'b0100;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge clk);
            #1;
            if (pops[0][2] == 8'd1) found = 1'b1;
        end
        if (!found) timeout("midrst first_pop");
        check("midrst rdreq_before", {28'd0, rdreq[0]}, 32'h4);
        rst = 1'b1;
        #1;
        check("midrst tx_valid", {31'd0, tx_valid[0]}, 32'd0);
        check("midrst tx_data", {24'd0, tx_data[0]}, 32'd0);
        check("midrst tx_last", {31'd0, tx_last[0]}, 32'd0);
        check("midrst busy", {31'd0, busy[0]}, 32'd0);
        check("midrst rdreq", {28'd0, rdreq[0]}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst pops_frozen", {24'd0, pops[0][2]}, 32'd1);
        start = cap_n[0];
        rst = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(posedge clk);
            #1;
            if (cap_n[0] >= start + 4) found = 1'b1;
        end
        have = '0;
        if (!found) timeout("midrst restart");
        check("midrst restart prefix", {24'd0, cap_data[0][start]}, 32'hAA);
        check("midrst restart src", {24'd0, cap_data[0][start+1]}, 32'h02);
        check("midrst restart len", {24'd0, cap_data[0][start+2]}, 32'h03);
        check("midrst restart data", {24'd0, cap_data[0][start+3]}, 32'h02);

        repeat (10) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
